apb_i2c_regfile: RTL

APB_I2C_REGFILE -- requirements
Module: apb_i2c_regfile

---
 rtl/apb_i2c_pkg.sv | 52 +++++
 rtl/sync_fifo.sv | 57 +++++
 rtl/apb_i2c_regfile.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/apb_i2c_pkg.sv
// Shared constants for the APB I2C register file: address map, STATUS and
// INT_STAT bit positions, and the register-select decode.
package apb_i2c_pkg;

    localparam int unsigned INT_W = 4;

    localparam logic [31:0] ADDR_TXDATA   = 32'h0000_0000;
    localparam logic [31:0] ADDR_RXDATA   = 32'h0000_0004;
    localparam logic [31:0] ADDR_CONFIG   = 32'h0000_0008;
    localparam logic [31:0] ADDR_TIMEOUT  = 32'h0000_000C;
    localparam logic [31:0] ADDR_STATUS   = 32'h0000_0010;
    localparam logic [31:0] ADDR_INT_EN   = 32'h0000_0014;
    localparam logic [31:0] ADDR_INT_STAT = 32'h0000_0018;

    // STATUS flag positions (levels occupy [7:0] and [15:8])
    localparam int unsigned ST_TX_EMPTY = 16;
    localparam int unsigned ST_TX_FULL  = 17;
    localparam int unsigned ST_RX_EMPTY = 18;
    localparam int unsigned ST_RX_FULL  = 19;

    // INT_STAT event positions
    localparam int unsigned IS_TX_DRAINED = 0;
    localparam int unsigned IS_RX_PUSH    = 1;
    localparam int unsigned IS_ERROR      = 2;
    localparam int unsigned IS_RX_OVF     = 3;

    typedef enum logic [2:0] {
        REG_TXDATA,
        REG_RXDATA,
        REG_CONFIG,
        REG_TIMEOUT,
        REG_STATUS,
        REG_INT_EN,
        REG_INT_STAT,
        REG_NONE
    } reg_e;

    // Full 32-bit compare: any stray address bit makes the access unmapped.
    function automatic reg_e decode_addr(input logic [31:0] addr);
        case (addr)
            ADDR_TXDATA:   return REG_TXDATA;
            ADDR_RXDATA:   return REG_RXDATA;
            ADDR_CONFIG:   return REG_CONFIG;
            ADDR_TIMEOUT:  return REG_TIMEOUT;
            ADDR_STATUS:   return REG_STATUS;
            ADDR_INT_EN:   return REG_INT_EN;
            ADDR_INT_STAT: return REG_INT_STAT;
            default:       return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with level output.
// Push at full and pop at empty are ignored; head reads 0 while empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];
    assign level   = count;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, written only on an accepted push outside reset
    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/apb_i2c_regfile.sv
// APB register file for an I2C core: TX/RX FIFOs, CONFIG/TIMEOUT control,
// STATUS, and sticky interrupt status with enable mask.
// Optional macro APB_I2C_REGFILE_READBACK_EN: when defined, CONFIG, TIMEOUT
// and INT_EN read back their values; otherwise those reads return 0.
module apb_i2c_regfile
    import apb_i2c_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CFG_W      = 14
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic              TX_RD_EN,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              TX_EMPTY,
    input  logic              RX_WR_EN,
    input  logic [DATA_W-1:0] RX_DATA,
    output logic              RX_FULL,
    input  logic              ERROR,
    output logic [CFG_W-1:0]  CFG,
    output logic [CFG_W-1:0]  TIMEOUT,
    output logic              IRQ
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    reg_e              reg_sel;
    logic              access;
    logic              bad;
    logic              wr_ok;
    logic              rd_ok;
    logic              tx_push;
    logic              rx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic              rx_full;
    logic              rx_empty;
    logic [LVL_W-1:0]  tx_level;
    logic [LVL_W-1:0]  rx_level;
    logic [DATA_W-1:0] rx_head;
    logic [31:0]       status_word;
    logic [CFG_W-1:0]  cfg_q;
    logic [CFG_W-1:0]  timeout_q;
    logic [INT_W-1:0]  int_en;
    logic [INT_W-1:0]  int_stat;
    logic [INT_W-1:0]  int_set;
    logic [INT_W-1:0]  int_clr;
    logic [INT_W-1:0]  int_stat_nxt;

    // Address decode and access error classification
    always_comb begin
        reg_sel = decode_addr(PADDR);
        access  = PSELx & PENABLE;
        bad     = 1'b0;
        case (reg_sel)
            REG_TXDATA: bad = ~PWRITE | tx_full;
            REG_RXDATA: bad = PWRITE | rx_empty;
            REG_STATUS: bad = PWRITE;
            REG_NONE:   bad = 1'b1;
            default:    bad = 1'b0;
        endcase
    end

    assign PREADY  = access;
    assign PSLVERR = access & bad;
    assign wr_ok   = access & ~bad & PWRITE;
    assign rd_ok   = access & ~bad & ~PWRITE;
    assign tx_push = wr_ok & (reg_sel == REG_TXDATA);
    assign rx_pop  = rd_ok & (reg_sel == REG_RXDATA);

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (tx_push),
        .wdata (PWDATA),
        .pop   (TX_RD_EN),
        .rdata (TX_DATA),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (RX_WR_EN),
        .wdata (RX_DATA),
        .pop   (rx_pop),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    assign TX_EMPTY = tx_empty;
    assign RX_FULL  = rx_full;
    assign CFG      = cfg_q;
    assign TIMEOUT  = timeout_q;
    assign IRQ      = |(int_stat & int_en);

    assign status_word = {12'd0, rx_full, rx_empty, tx_full, tx_empty,
                          8'(rx_level), 8'(tx_level)};

    // Interrupt event collection; a same-cycle set overrides the W1C clear
    always_comb begin
        int_set                = '0;
        int_set[IS_TX_DRAINED] = (tx_level == LVL_W'(1)) & TX_RD_EN & ~tx_push;
        int_set[IS_RX_PUSH]    = RX_WR_EN & ~rx_full;
        int_set[IS_ERROR]      = ERROR;
        int_set[IS_RX_OVF]     = RX_WR_EN & rx_full;
        int_clr                = (wr_ok && reg_sel == REG_INT_STAT) ? PWDATA[INT_W-1:0] : '0;
        int_stat_nxt           = (int_stat & ~int_clr) | int_set;
    end

    // Control and interrupt registers
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            cfg_q     <= '0;
            timeout_q <= '0;
            int_en    <= '0;
            int_stat  <= '0;
        end else begin
            if (wr_ok && reg_sel == REG_CONFIG)  cfg_q     <= PWDATA[CFG_W-1:0];
            if (wr_ok && reg_sel == REG_TIMEOUT) timeout_q <= PWDATA[CFG_W-1:0];
            if (wr_ok && reg_sel == REG_INT_EN)  int_en    <= PWDATA[INT_W-1:0];
            int_stat <= int_stat_nxt;
        end
    end

    // Read data mux; non-valid reads return 0
    always_comb begin
        PRDATA = '0;
        if (rd_ok) begin
            case (reg_sel)
                REG_RXDATA:   PRDATA = rx_head;
                REG_STATUS:   PRDATA = DATA_W'(status_word);
                REG_INT_STAT: PRDATA = DATA_W'(int_stat);
`ifdef APB_I2C_REGFILE_READBACK_EN
                REG_CONFIG:   PRDATA = DATA_W'(cfg_q);
                REG_TIMEOUT:  PRDATA = DATA_W'(timeout_q);
                REG_INT_EN:   PRDATA = DATA_W'(int_en);
`endif
                default:      PRDATA = '0;
            endcase
        end
    end

endmodule
